// File: rtl/fpu_mul_rm.sv
// Multi-cycle IEEE-754 multiplier with selectable rounding mode and {NV,OF,UF,NX} flags.
// Define FPU_MUL_SUBNORMAL_EN for gradual underflow; otherwise subnormals flush to zero.
module fpu_mul_rm #(
    parameter  int EXPONENT = 8,
    parameter  int MANTISSA = 23,
    localparam int WIDTH    = EXPONENT + MANTISSA + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_rm,
    input  logic             in_stb,
    output logic             in_ack,
    output logic [WIDTH-1:0] out_z,
    output logic [3:0]       out_flags,
    output logic             out_stb,
    input  logic             out_ack
);

    localparam int BIAS    = (1 << (EXPONENT - 1)) - 1;
    // Wide enough for the most negative product exponent of two normalised subnormals.
    localparam int EW_NEED = $clog2(2 * (BIAS + MANTISSA) + 4) + 1;
    localparam int EW      = (EXPONENT + 2 > EW_NEED) ? EXPONENT + 2 : EW_NEED;
    localparam int MW      = MANTISSA + 1;
    localparam int PW      = 2 * MW;

    localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
    localparam logic signed [EW-1:0] E_MIN  = EW'(1 - BIAS);
    localparam logic signed [EW-1:0] E_INF  = EW'(BIAS + 1);
    localparam logic signed [EW-1:0] E_ZERO = EW'(-BIAS);
    localparam logic signed [EW-1:0] E_ONE  = EW'(1);

    localparam logic [WIDTH-1:0] QNAN = {1'b1, {EXPONENT{1'b1}}, 1'b1, {(MANTISSA-1){1'b0}}};

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_UNPACK  = 4'd1;
    localparam logic [3:0] S_SPECIAL = 4'd2;
    localparam logic [3:0] S_NORM_A  = 4'd3;
    localparam logic [3:0] S_NORM_B  = 4'd4;
    localparam logic [3:0] S_MUL     = 4'd5;
    localparam logic [3:0] S_NORM_1  = 4'd6;
    localparam logic [3:0] S_NORM_2  = 4'd7;
    localparam logic [3:0] S_ROUND   = 4'd8;
    localparam logic [3:0] S_PACK    = 4'd9;
    localparam logic [3:0] S_PUT     = 4'd10;

    logic [3:0]              state_q, state_d;
    logic [WIDTH-1:0]        a_q, a_d, b_q, b_d;
    logic [1:0]              rm_q, rm_d;
    logic                    a_s_q, a_s_d, b_s_q, b_s_d;
    logic signed [EW-1:0]    a_e_q, a_e_d, b_e_q, b_e_d;
    logic [MW-1:0]           a_m_q, a_m_d, b_m_q, b_m_d;
    logic                    z_s_q, z_s_d;
    logic signed [EW-1:0]    z_e_q, z_e_d;
    logic [MW-1:0]           z_m_q, z_m_d;
    logic [PW-1:0]           prod_q, prod_d;
    logic                    g_q, g_d, r_q, r_d, s_q, s_d;
    logic                    inx_q, inx_d, tiny_q, tiny_d;
    logic [WIDTH-1:0]        z_out_q, z_out_d;
    logic [3:0]              flags_q, flags_d;
    logic                    stb_q, stb_d, ack_q, ack_d;

    logic                    a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, snan;
    logic [PW-1:0]           prod_n;
    logic                    inc, to_inf;

    assign a_nan = (a_e_q == E_INF) && (a_m_q[MANTISSA-1:0] != '0);
    assign b_nan = (b_e_q == E_INF) && (b_m_q[MANTISSA-1:0] != '0);
    assign a_inf = (a_e_q == E_INF) && (a_m_q[MANTISSA-1:0] == '0);
    assign b_inf = (b_e_q == E_INF) && (b_m_q[MANTISSA-1:0] == '0);
`ifdef FPU_MUL_SUBNORMAL_EN
    assign a_zero = (a_e_q == E_ZERO) && (a_m_q[MANTISSA-1:0] == '0);
    assign b_zero = (b_e_q == E_ZERO) && (b_m_q[MANTISSA-1:0] == '0);
`else
    assign a_zero = (a_e_q == E_ZERO);
    assign b_zero = (b_e_q == E_ZERO);
`endif
    assign snan   = (a_nan && !a_m_q[MANTISSA-1]) || (b_nan && !b_m_q[MANTISSA-1]);
    assign prod_n = prod_q[PW-1] ? prod_q : (prod_q << 1);
    assign to_inf = (rm_q == 2'b00) || (rm_q == 2'b10 && !z_s_q) || (rm_q == 2'b11 && z_s_q);

    always_comb begin
        case (rm_q)
            2'b00:   inc = g_q & (r_q | s_q | z_m_q[0]);
            2'b10:   inc = !z_s_q & (g_q | r_q | s_q);
            2'b11:   inc = z_s_q & (g_q | r_q | s_q);
            default: inc = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d = a_q;  b_d = b_q;  rm_d = rm_q;
        a_s_d = a_s_q;  b_s_d = b_s_q;
        a_e_d = a_e_q;  b_e_d = b_e_q;
        a_m_d = a_m_q;  b_m_d = b_m_q;
        z_s_d = z_s_q;  z_e_d = z_e_q;  z_m_d = z_m_q;
        prod_d = prod_q;
        g_d = g_q;  r_d = r_q;  s_d = s_q;
        inx_d = inx_q;  tiny_d = tiny_q;
        z_out_d = z_out_q;  flags_d = flags_q;
        stb_d = stb_q;  ack_d = ack_q;

        case (state_q)
            S_IDLE: begin
                if (ack_q && in_stb) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    rm_d    = in_rm;
                    ack_d   = 1'b0;
                    state_d = S_UNPACK;
                end else begin
                    ack_d = 1'b1;
                end
            end
            S_UNPACK: begin
                a_s_d   = a_q[WIDTH-1];
                b_s_d   = b_q[WIDTH-1];
                a_e_d   = $signed({{(EW-EXPONENT){1'b0}}, a_q[WIDTH-2 -: EXPONENT]}) - E_BIAS;
                b_e_d   = $signed({{(EW-EXPONENT){1'b0}}, b_q[WIDTH-2 -: EXPONENT]}) - E_BIAS;
                a_m_d   = {1'b0, a_q[MANTISSA-1:0]};
                b_m_d   = {1'b0, b_q[MANTISSA-1:0]};
                state_d = S_SPECIAL;
            end
            S_SPECIAL: begin
                if (a_nan || b_nan) begin
                    z_out_d = QNAN;
                    flags_d = {snan, 3'b000};
                    stb_d   = 1'b1;
                    state_d = S_PUT;
                end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
                    z_out_d = QNAN;
                    flags_d = 4'b1000;
                    stb_d   = 1'b1;
                    state_d = S_PUT;
                end else if (a_inf || b_inf) begin
                    z_out_d = {a_s_q ^ b_s_q, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
                    flags_d = '0;
                    stb_d   = 1'b1;
                    state_d = S_PUT;
                end else if (a_zero || b_zero) begin
                    z_out_d = {a_s_q ^ b_s_q, {(WIDTH-1){1'b0}}};
                    flags_d = '0;
                    stb_d   = 1'b1;
                    state_d = S_PUT;
                end else begin
                    if (a_e_q == E_ZERO) a_e_d = E_MIN;
                    else                 a_m_d[MANTISSA] = 1'b1;
                    if (b_e_q == E_ZERO) b_e_d = E_MIN;
                    else                 b_m_d[MANTISSA] = 1'b1;
                    state_d = S_NORM_A;
                end
            end
            S_NORM_A: begin
`ifdef FPU_MUL_SUBNORMAL_EN
                if (!a_m_q[MANTISSA]) begin
                    a_m_d = a_m_q << 1;
                    a_e_d = a_e_q - E_ONE;
                end else begin
                    state_d = S_NORM_B;
                end
`else
                state_d = S_NORM_B;
`endif
            end
            S_NORM_B: begin
`ifdef FPU_MUL_SUBNORMAL_EN
                if (!b_m_q[MANTISSA]) begin
                    b_m_d = b_m_q << 1;
                    b_e_d = b_e_q - E_ONE;
                end else begin
                    state_d = S_MUL;
                end
`else
                state_d = S_MUL;
`endif
            end
            S_MUL: begin
                z_s_d   = a_s_q ^ b_s_q;
                z_e_d   = a_e_q + b_e_q + E_ONE;
                prod_d  = PW'(a_m_q) * PW'(b_m_q);
                state_d = S_NORM_1;
            end
            S_NORM_1: begin
                if (!prod_q[PW-1]) z_e_d = z_e_q - E_ONE;
                z_m_d = prod_n[PW-1 -: MW];
                g_d   = prod_n[MANTISSA];
                r_d   = prod_n[MANTISSA-1];
                s_d   = |prod_n[MANTISSA-2:0];
`ifdef FPU_MUL_SUBNORMAL_EN
                state_d = S_NORM_2;
`else
                state_d = S_ROUND;
`endif
            end
            S_NORM_2: begin
                if (z_e_q < E_MIN) begin
                    z_m_d = z_m_q >> 1;
                    g_d   = z_m_q[0];
                    r_d   = g_q;
                    s_d   = s_q | r_q;
                    z_e_d = z_e_q + E_ONE;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                inx_d = g_q | r_q | s_q;
`ifdef FPU_MUL_SUBNORMAL_EN
                tiny_d = !z_m_q[MANTISSA];
`else
                tiny_d = (z_e_q < E_MIN);
`endif
                if (inc) begin
                    if (&z_m_q) begin
                        z_m_d = {1'b1, {MANTISSA{1'b0}}};
                        z_e_d = z_e_q + E_ONE;
                    end else begin
                        z_m_d = z_m_q + 1'b1;
                    end
                end
                state_d = S_PACK;
            end
            S_PACK: begin
                stb_d   = 1'b1;
                state_d = S_PUT;
`ifndef FPU_MUL_SUBNORMAL_EN
                if (tiny_q) begin
                    z_out_d = {z_s_q, {(WIDTH-1){1'b0}}};
                    flags_d = 4'b0011;
                end else
`endif
                if (z_e_q > E_BIAS) begin
                    if (to_inf) z_out_d = {z_s_q, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
                    else        z_out_d = {z_s_q, {(EXPONENT-1){1'b1}}, 1'b0, {MANTISSA{1'b1}}};
                    flags_d = 4'b0101;
                end else begin
                    // A cleared hidden bit here means the result stayed subnormal after rounding.
                    z_out_d = {z_s_q,
                               z_m_q[MANTISSA] ? EXPONENT'(z_e_q + E_BIAS) : {EXPONENT{1'b0}},
                               z_m_q[MANTISSA-1:0]};
                    flags_d = {1'b0, 1'b0, tiny_q & inx_q, inx_q};
                end
            end
            S_PUT: begin
                if (out_ack) begin
                    stb_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            a_q <= '0;  b_q <= '0;  rm_q <= '0;
            a_s_q <= 1'b0;  b_s_q <= 1'b0;
            a_e_q <= '0;  b_e_q <= '0;
            a_m_q <= '0;  b_m_q <= '0;
            z_s_q <= 1'b0;  z_e_q <= '0;  z_m_q <= '0;
            prod_q <= '0;
            g_q <= 1'b0;  r_q <= 1'b0;  s_q <= 1'b0;
            inx_q <= 1'b0;  tiny_q <= 1'b0;
            z_out_q <= '0;  flags_q <= '0;
            stb_q <= 1'b0;  ack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;  b_q <= b_d;  rm_q <= rm_d;
            a_s_q <= a_s_d;  b_s_q <= b_s_d;
            a_e_q <= a_e_d;  b_e_q <= b_e_d;
            a_m_q <= a_m_d;  b_m_q <= b_m_d;
            z_s_q <= z_s_d;  z_e_q <= z_e_d;  z_m_q <= z_m_d;
            prod_q <= prod_d;
            g_q <= g_d;  r_q <= r_d;  s_q <= s_d;
            inx_q <= inx_d;  tiny_q <= tiny_d;
            z_out_q <= z_out_d;  flags_q <= flags_d;
            stb_q <= stb_d;  ack_q <= ack_d;
        end
    end

    assign in_ack    = ack_q;
    assign out_z     = z_out_q;
    assign out_flags = flags_q;
    assign out_stb   = stb_q;

endmodule

// File: tb/tb_fpu_mul_rm.sv
// Directed scoreboard bench for fpu_mul_rm in binary32; expectations follow FPU_MUL_SUBNORMAL_EN.
module tb_fpu_mul_rm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_a = '0, in_b = '0;
    logic [1:0]  in_rm = '0;
    logic        in_stb = 1'b0;
    logic        in_ack;
    logic [31:0] out_z;
    logic [3:0]  out_flags;
    logic        out_stb;
    logic        out_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] z;
        logic [3:0]  f;
        int          lat;
    } exp_t;
    exp_t sb[$];

`ifdef FPU_MUL_SUBNORMAL_EN
    localparam int LAT_FIN = 9;
`else
    localparam int LAT_FIN = 8;
`endif

    fpu_mul_rm #(.EXPONENT(8), .MANTISSA(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_rm     (in_rm),
        .in_stb    (in_stb),
        .in_ack    (in_ack),
        .out_z     (out_z),
        .out_flags (out_flags),
        .out_stb   (out_stb),
        .out_ack   (out_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] rm, input logic [31:0] ez, input logic [3:0] ef,
                         input int elat, input int hold, input bit early_ack);
        exp_t e;
        int   n;
        int   lat;
        bit   stable;
        logic [31:0] zh;
        e.z = ez; e.f = ef; e.lat = elat;
        sb.push_back(e);
        @(negedge clk);
        n = 0;
        while (in_ack !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, 32'(in_ack), 32'd1);
        in_a = a; in_b = b; in_rm = rm; in_stb = 1'b1;
        @(posedge clk);
        #1;
        in_stb = 1'b0;
        in_a = 32'hDEADBEEF; in_b = 32'h12345678; in_rm = ~rm;
        if (early_ack) out_ack = 1'b1;
        lat = 0;
        while (out_stb !== 1'b1 && lat < 400) begin
            @(posedge clk);
            lat++;
            #1;
        end
        e = sb.pop_front();
        chk({tag, "_z"}, out_z, e.z);
        chk({tag, "_flags"}, 32'(out_flags), 32'(e.f));
        chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
        if (!early_ack) begin
            zh = out_z;
            stable = 1'b1;
            repeat (hold) begin
                @(posedge clk);
                #1;
                if (out_stb !== 1'b1 || out_z !== zh || in_ack !== 1'b0) stable = 1'b0;
            end
            if (hold > 0) chk({tag, "_hold"}, 32'(stable), 32'd1);
            @(negedge clk);
            out_ack = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({tag, "_handshake"}, {30'd0, out_stb, in_ack}, 32'b01);
        @(negedge clk);
        out_ack = 1'b0;
    endtask

    initial begin
        bit quiet;
        #1;
        chk("reset_outs", {out_z[27:0], out_flags}, 32'd0);
        chk("reset_ctl", {30'd0, out_stb, in_ack}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("first_ack", 32'(in_ack), 32'd1);

        do_op("mul3x2", 32'h40400000, 32'h40000000, 2'b00, 32'h40C00000, 4'b0000, LAT_FIN, 5, 1'b0);
        do_op("inf_x0", 32'h7F800000, 32'h00000000, 2'b00, 32'hFFC00000, 4'b1000, 2, 0, 1'b0);
        do_op("snan", 32'h7FA00000, 32'h3F800000, 2'b00, 32'hFFC00000, 4'b1000, 2, 0, 1'b0);
        do_op("qnan", 32'h7FC00000, 32'h3F800000, 2'b00, 32'hFFC00000, 4'b0000, 2, 0, 1'b0);
        do_op("inf_neg", 32'h7F800000, 32'hC0000000, 2'b00, 32'hFF800000, 4'b0000, 2, 0, 1'b1);
        do_op("negzero", 32'h80000000, 32'h40A00000, 2'b00, 32'h80000000, 4'b0000, 2, 0, 1'b0);
        do_op("ulp_rne", 32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002, 4'b0001, LAT_FIN, 0, 1'b0);
        do_op("ulp_rup", 32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800003, 4'b0001, LAT_FIN, 0, 1'b1);
        do_op("ulp_rtz", 32'h3F800001, 32'h3F800001, 2'b01, 32'h3F800002, 4'b0001, LAT_FIN, 0, 1'b0);
        do_op("ulp_rdn", 32'h3F800001, 32'h3F800001, 2'b11, 32'h3F800002, 4'b0001, LAT_FIN, 0, 1'b0);
        do_op("ovf_rne", 32'h7F7FFFFF, 32'h40000000, 2'b00, 32'h7F800000, 4'b0101, LAT_FIN, 0, 1'b0);
        do_op("ovf_rtz", 32'h7F7FFFFF, 32'h40000000, 2'b01, 32'h7F7FFFFF, 4'b0101, LAT_FIN, 0, 1'b0);
        do_op("ovf_rup", 32'h7F7FFFFF, 32'hC0000000, 2'b10, 32'hFF7FFFFF, 4'b0101, LAT_FIN, 0, 1'b0);
        do_op("ovf_rdn", 32'h7F7FFFFF, 32'hC0000000, 2'b11, 32'hFF800000, 4'b0101, LAT_FIN, 0, 1'b0);
`ifdef FPU_MUL_SUBNORMAL_EN
        do_op("tiny", 32'h00800000, 32'h3F000000, 2'b00, 32'h00400000, 4'b0000, LAT_FIN + 1, 0, 1'b0);
        do_op("subin", 32'h00000001, 32'h3F800000, 2'b00, 32'h00000001, 4'b0000, LAT_FIN + 46, 0, 1'b0);
`else
        do_op("tiny", 32'h00800000, 32'h3F000000, 2'b00, 32'h00000000, 4'b0011, LAT_FIN, 0, 1'b0);
        do_op("subin", 32'h00000001, 32'h3F800000, 2'b00, 32'h00000000, 4'b0000, 2, 0, 1'b0);
`endif

        // Abort a long underflowing multiply partway through with reset.
        @(negedge clk);
        in_a = 32'h00800000; in_b = 32'h20000000; in_rm = 2'b00; in_stb = 1'b1;
        @(posedge clk);
        #1;
        in_stb = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_z", out_z, 32'd0);
        chk("rst_mid_ctl", {26'd0, out_flags, out_stb, in_ack}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release_ack", 32'(in_ack), 32'd1);
        quiet = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_stb !== 1'b0) quiet = 1'b0;
        end
        chk("rst_no_result", 32'(quiet), 32'd1);

        do_op("after_rst", 32'h40400000, 32'h40000000, 2'b00, 32'h40C00000, 4'b0000, LAT_FIN, 0, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
